// File: rtl/mem_pkg.sv
// Shared constants for the unified memory and its multi-cycle controller.
// No logic; types and constants only.
// Used by mem_latency_unit and the control unit's state-count assumptions.
package mem_pkg;

    // Access FSM encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Default access latency. The control unit's IF/MEM state counts assume it.
    localparam int unsigned MEM_LATENCY_DEFAULT = 4;

    // Bits of byte offset inside a word.
    localparam int unsigned WORD_OFS_W = 2;

    // Width of the latency down-counter. It covers LATENCY up to 15.
    localparam int unsigned CNT_W = 4;

    function automatic logic is_misaligned(input logic [WORD_OFS_W-1:0] ofs);
        return ofs != '0;
    endfunction

endpackage

// File: rtl/mem_latency_unit_if.sv
// Request/response bundle between the controller and the unified memory.
// Combinational wires only. This interface adds no latency.
// Handshake: a request transfers when req_valid && req_ready. resp_valid is a one-cycle pulse.
// Ports: req_valid/req_ready/req_write/req_addr/req_wdata, resp_valid/resp_rdata/resp_err, busy
interface mem_latency_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic              busy;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, busy
    );
endinterface

// File: rtl/mem_word_array.sv
// Word storage for the unified memory: one write and one registered read per clock.
// Latency: the read result appears on rdata_o one clock after re_i.
// Backpressure: none. The array is always ready. Contents are never reset.
// Ports: clk, we_i/waddr_i/wdata_i (write), re_i/raddr_i (read), rdata_o
module mem_word_array #(
    parameter int DEPTH_WORDS = 16384,
    parameter int DATA_W      = 32,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
    logic [DATA_W-1:0] rdata_q;

    // A read and a write to the same word can happen in the same cycle.
    // This occurs at LATENCY=1, when a store commits while the next load is accepted.
    // In that case the read returns the new data.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_latency_unit.sv
// Unified I/D memory with a fixed access latency and a one-cycle completion pulse.
// Latency: a request accepted at edge T has resp_valid=1 in the cycle after edge T+LATENCY-1.
// Backpressure: req_ready=0 while an access is in WAIT. Requests offered then are dropped, not queued.
// Ports: clk, reset (sync, active-high), bus (slave side of mem_latency_unit_if)
module mem_latency_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 16384,
    parameter int LATENCY     = MEM_LATENCY_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    mem_latency_unit_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              accept;
    logic              misal;
    logic              arr_we;
    logic              arr_re;
    logic [IDX_W-1:0]  arr_raddr;
    logic [IDX_W-1:0]  req_idx;
    logic [IDX_W-1:0]  lat_idx;
    logic [DATA_W-1:0] arr_rdata;

    // The word index keeps only enough address bits for the array depth.
    // Higher address bits wrap silently.
    assign req_idx = bus.req_addr[WORD_OFS_W +: IDX_W];
    assign lat_idx = addr_q[WORD_OFS_W +: IDX_W];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.req_addr[ADDR_W-1:IDX_W+WORD_OFS_W],
                                bus.req_addr[WORD_OFS_W-1:0],
                                addr_q[ADDR_W-1:IDX_W+WORD_OFS_W]};

    assign accept = bus.req_valid && bus.req_ready;
    assign misal  = is_misaligned(addr_q[WORD_OFS_W-1:0]);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        case (state_q)
            IDLE: state_d = IDLE;
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                // The counter reaches 0 on this edge, so the next cycle is the response.
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // accept can only be high in IDLE or DONE, because ready is low in WAIT.
        if (accept) begin
            wr_d    = bus.req_write;
            addr_d  = bus.req_addr;
            wdata_d = bus.req_wdata;
            cnt_d   = LAT_M1;
            state_d = (LATENCY == 1) ? DONE : WAIT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // A load is read on the edge that enters DONE.
    // Normally the address comes from the latch.
    // At LATENCY=1 the access is accepted on that same edge, so the address comes from the request.
    assign arr_re    = (state_d == DONE) && !reset;
    assign arr_raddr = accept ? req_idx : lat_idx;

    // A store commits on the edge that leaves DONE.
    // Misaligned stores and stores cut off by reset are dropped.
    assign arr_we = (state_q == DONE) && wr_q && !misal && !reset;

    mem_word_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .DATA_W      (DATA_W),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk     (clk),
        .we_i    (arr_we),
        .waddr_i (lat_idx),
        .wdata_i (wdata_q),
        .re_i    (arr_re),
        .raddr_i (arr_raddr),
        .rdata_o (arr_rdata)
    );

    assign bus.req_ready  = (state_q != WAIT);
    assign bus.busy       = (state_q == WAIT);
    assign bus.resp_valid = (state_q == DONE);
    assign bus.resp_err   = (state_q == DONE) && misal;
    assign bus.resp_rdata = ((state_q == DONE) && !wr_q && !misal) ? arr_rdata : '0;

endmodule
